// File: rtl/widths_union_pack_if.sv
// Byte-in / word-out handshake bundle for widths_union_pack.
interface widths_union_pack_if;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_word;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output in_byte, in_valid, out_ready,
      input  in_ready, out_word, out_valid
   );

   modport slave (
      input  in_byte, in_valid, out_ready,
      output in_ready, out_word, out_valid
   );
endinterface

// File: rtl/widths_union_pack.sv
// Pairs consecutive bytes into 16-bit words behind a registered
// valid/ready output; one byte per clock sustained.
module widths_union_pack #(
   parameter bit HIGH_FIRST = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   widths_union_pack_if.slave   bus,
   input  logic                 flush,
   output logic                 half_full,
   output logic [CNT_W-1:0]     word_cnt
);

   logic [7:0]       first_q, first_d;
   logic             half_q, half_d;
   logic             vld_q, vld_d;
   logic [15:0]      word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, pop;

   // A first byte never needs the output slot, so it is always taken.
   assign bus.in_ready  = !half_q || !vld_q || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign pop           = vld_q && bus.out_ready;
   assign bus.out_word  = word_q;
   assign bus.out_valid = vld_q;
   assign half_full     = half_q;
   assign word_cnt      = cnt_q;

   always_comb begin
      first_d = first_q;
      half_d  = half_q;
      vld_d   = vld_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      if (pop) vld_d = 1'b0;
      if (flush) half_d = 1'b0;
      if (accept) begin
         // A flush in the same cycle demotes this byte to a first byte.
         if (half_q && !flush) begin
            word_d = HIGH_FIRST ? {first_q, bus.in_byte}
                                : {bus.in_byte, first_q};
            vld_d  = 1'b1;
            half_d = 1'b0;
            cnt_d  = cnt_q + 1'b1;
         end else begin
            first_d = bus.in_byte;
            half_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         first_q <= '0;
         half_q  <= 1'b0;
         vld_q   <= 1'b0;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         first_q <= first_d;
         half_q  <= half_d;
         vld_q   <= vld_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_widths_union_pack.sv
// Directed bench: three instances (low-first, high-first, 4-bit counter)
// share one byte stream and are checked against hand-computed values.
module tb_widths_union_pack;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_byte = '0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       flush = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   logic        h0, h1, h2;
   logic [15:0] c0, c1;
   logic [3:0]  c2;

   widths_union_pack_if ifa ();
   widths_union_pack_if ifb ();
   widths_union_pack_if ifc ();

   assign ifa.in_byte = in_byte;
   assign ifa.in_valid = in_valid;
   assign ifa.out_ready = out_ready;
   assign ifb.in_byte = in_byte;
   assign ifb.in_valid = in_valid;
   assign ifb.out_ready = out_ready;
   assign ifc.in_byte = in_byte;
   assign ifc.in_valid = in_valid;
   assign ifc.out_ready = out_ready;

   widths_union_pack #(.HIGH_FIRST(1'b0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .bus(ifa.slave), .flush(flush),
      .half_full(h0), .word_cnt(c0));
   widths_union_pack #(.HIGH_FIRST(1'b1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .bus(ifb.slave), .flush(flush),
      .half_full(h1), .word_cnt(c1));
   widths_union_pack #(.HIGH_FIRST(1'b0), .CNT_W(4)) u2 (
      .clk(clk), .rst(rst), .bus(ifc.slave), .flush(flush),
      .half_full(h2), .word_cnt(c2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] b,
                        input logic r, input logic f);
      in_valid = v;
      in_byte = b;
      out_ready = r;
      flush = f;
      #1;
   endtask

   initial begin
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_word", 32'(ifa.out_word), 32'h0);
      chk("rst_valid", 32'(ifa.out_valid), 32'h0);
      chk("rst_half", 32'(h0), 32'h0);
      chk("rst_cnt", 32'(c0), 32'h0);
      chk("rst_ready", 32'(ifa.in_ready), 32'h1);

      // pair 0x34,0x12
      drive(1'b1, 8'h34, 1'b1, 1'b0);
      cyc();
      chk("t1_half", 32'(h0), 32'h1);
      drive(1'b1, 8'h12, 1'b1, 1'b0);
      cyc();
      chk("t1_valid", 32'(ifa.out_valid), 32'h1);
      chk("t1_word_lo", 32'(ifa.out_word), 32'h1234);
      chk("t1_word_hi", 32'(ifb.out_word), 32'h3412);
      chk("t1_cnt", 32'(c0), 32'h1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
      chk("t1_valid_drop", 32'(ifa.out_valid), 32'h0);
      chk("t1_cnt_hold", 32'(c0), 32'h1);

      // continuous stream 0x01..0x08
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 8'(k + 1), 1'b1, 1'b0);
         cyc();
         chk("t2_valid", 32'(ifb.out_valid), 32'(k % 2));
         if (k % 2 == 1)
            chk("t2_word", 32'(ifb.out_word), {16'h0, 8'(k), 8'(k + 1)});
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
      chk("t2_cnt", 32'(c1), 32'h5);
      chk("t2_last_lo", 32'(ifa.out_word), 32'h0807);

      // backpressure
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 8'hBB, 1'b0, 1'b0);
      cyc();
      chk("t3_word", 32'(ifa.out_word), 32'hBBAA);
      drive(1'b1, 8'hCC, 1'b0, 1'b0);
      chk("t3_rdy_cc", 32'(ifa.in_ready), 32'h1);
      cyc();
      drive(1'b1, 8'hDD, 1'b0, 1'b0);
      chk("t3_rdy_dd", 32'(ifa.in_ready), 32'h0);
      cyc();
      chk("t3_hold", 32'(ifa.out_word), 32'hBBAA);
      chk("t3_half", 32'(h0), 32'h1);
      cyc();
      chk("t3_hold2", 32'(ifa.out_word), 32'hBBAA);
      chk("t3_valid2", 32'(ifa.out_valid), 32'h1);
      drive(1'b1, 8'hDD, 1'b1, 1'b0);
      chk("t3_rdy_go", 32'(ifa.in_ready), 32'h1);
      cyc();
      chk("t3_word2", 32'(ifa.out_word), 32'hDDCC);
      chk("t3_valid3", 32'(ifa.out_valid), 32'h1);
      chk("t3_cnt", 32'(c0), 32'h7);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
      chk("t3_drain", 32'(ifa.out_valid), 32'h0);

      // flush
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      cyc();
      chk("t4_half", 32'(h0), 32'h1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      cyc();
      chk("t4_flushed", 32'(h0), 32'h0);
      drive(1'b1, 8'h66, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 8'h77, 1'b1, 1'b0);
      cyc();
      chk("t4_word", 32'(ifa.out_word), 32'h7766);
      drive(1'b1, 8'h99, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 8'h88, 1'b1, 1'b1);
      cyc();
      chk("t4_half_88", 32'(h0), 32'h1);
      chk("t4_valid_88", 32'(ifa.out_valid), 32'h0);
      drive(1'b1, 8'h11, 1'b1, 1'b0);
      cyc();
      chk("t4_word_88", 32'(ifa.out_word), 32'h1188);
      chk("t4_word_88h", 32'(ifb.out_word), 32'h8811);
      chk("t4_cnt", 32'(c0), 32'h9);

      // reset with word pending and half pair held
      drive(1'b1, 8'h22, 1'b0, 1'b0);
      cyc();
      chk("t5_pre_v", 32'(ifa.out_valid), 32'h1);
      chk("t5_pre_h", 32'(h0), 32'h1);
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      rst = 1'b0;
      chk("t5_valid", 32'(ifa.out_valid), 32'h0);
      chk("t5_half", 32'(h0), 32'h0);
      chk("t5_cnt", 32'(c0), 32'h0);
      chk("t5_word", 32'(ifa.out_word), 32'h0);
      chk("t5_ready", 32'(ifa.in_ready), 32'h1);

      // 17 words: 4-bit counter wraps to 1
      for (int k = 0; k < 34; k++) begin
         drive(1'b1, 8'(k), 1'b1, 1'b0);
         cyc();
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
      chk("t6_wrap", 32'(c2), 32'h1);
      chk("t6_cnt16", 32'(c0), 32'd17);
      chk("t6_word", 32'(ifc.out_word), 32'h2120);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/widths_union_pack.md
Name: widths_union_pack

Overview:
Byte-to-word assembler, the inverse of the 16-bit union split used in the widths_union test set. Accepts a stream of bytes over a valid/ready handshake and pairs consecutive bytes into 16-bit words (low/high halves). The assembled words are presented on a registered valid/ready output. The block sits between a byte-serial source and any consumer of the 16-bit union view, and sustains one byte per clock.

Parameters:
HIGH_FIRST, 0, 0 = first byte of a pair is the low byte [7:0]; 1 = first byte is the high byte [15:8].
CNT_W, 16, width of the completed-word counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_byte  input  8  byte data
in_valid  input  1  byte offered
in_ready  output  1  byte accepted when in_valid && in_ready
flush  input  1  synchronous drop of any half-assembled pair
out_word  output  16  assembled word {high, low}
out_valid  output  1  word available
out_ready  input  1  consumer takes word when out_valid && out_ready
half_full  output  1  one byte of a pair held
word_cnt  output  CNT_W  words completed since reset (wraps)

Behaviour:
- Synchronous active-high reset; all registers update on rising clk only.
- Reset values: out_word=0, out_valid=0, half_full=0, word_cnt=0. in_ready is combinational and equals 1 out of reset.
- State = {half_full, out_valid}. Byte register `first_q` holds the pending first byte.
- in_ready = !half_full || !out_valid || out_ready. A first byte may always be taken, even when the output is occupied.
- Accept with half_full=0: first_q<=in_byte, half_full<=1. out_valid is unaffected, except that it clears if the held word is taken in the same cycle.
- Accept with half_full=1 (second byte):
  - HIGH_FIRST=0: out_word<={in_byte, first_q}.
  - HIGH_FIRST=1: out_word<={first_q, in_byte}.
  - out_valid<=1, half_full<=0, word_cnt<=word_cnt+1 (mod 2^CNT_W).
- Output pop (out_valid && out_ready) with no completing byte in the same cycle: out_valid<=0. out_word holds its last value.
- Simultaneous pop and completing byte: the new word replaces the old one and out_valid stays 1. This gives back-to-back words, one every 2 cycles at full byte rate.
- Latency: second byte accepted at cycle N -> out_valid=1 at N+1.
- out_word is stable while out_valid && !out_ready.
- flush:
  - Clears half_full the next cycle and discards first_q.
  - Does not affect out_valid, out_word or word_cnt.
  - A byte accepted in the same cycle as flush is treated as a first byte (half_full<=1, first_q<=in_byte), so flush wins over the pair pending before it.
- rst asserted mid-pair or with a word pending: everything returns to reset values next cycle. The partial byte and unconsumed word are lost.
- Output backpressure: half_full=1 && out_valid=1 && out_ready=0 -> in_ready=0 and no byte is lost.
- in_byte is ignored when in_valid=0. A source that drops in_valid while in_ready=0 is not checked.

Test Plan:
1. HIGH_FIRST=0, out_ready=1, bytes 0x34,0x12 on consecutive cycles -> out_word=0x1234, out_valid=1 for exactly one cycle, one cycle after 0x12 accepted; word_cnt=1.
2. HIGH_FIRST=1, bytes 0x34,0x12 -> out_word=0x3412. Then continuous stream 0x01..0x08 with out_ready=1 -> words 0x0102,0x0304,0x0506,0x0708 every 2 cycles; word_cnt=5.
3. Backpressure: out_ready=0, bytes 0xAA,0xBB,0xCC,0xDD -> in_ready=1 for 0xAA,0xBB,0xCC, then in_ready=0 while 0xDD is offered; out_word holds 0xBBAA (HIGH_FIRST=0). Raise out_ready one cycle -> 0xDD accepted in that cycle, out_word=0xDDCC next cycle.
4. flush: byte 0x55 accepted, then flush=1 with in_valid=0 -> half_full=0. Next bytes 0x66,0x77 -> out_word=0x7766; 0x55 never appears. Repeat with flush and byte 0x88 in the same cycle -> half_full=1 holding 0x88.
5. Reset mid-operation: one word pending (out_valid=1) and half_full=1, assert rst one cycle -> out_valid=0, half_full=0, word_cnt=0, out_word=0, in_ready=1.
6. Counter wrap with CNT_W=4: complete 17 words -> word_cnt=1.
